znew_seq: RTL and testbench

ZNEW_SEQ -- requirements
Module: znew_seq

---
 rtl/znew_seq.sv | 140 ++++++++++++++
 tb/tb_znew_seq.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/znew_seq.sv
// znew_seq: CORDIC angle-path sequencer.
// Steps a binary-angle accumulator through ITER micro-rotations.
module znew_seq #(
   parameter int WIDTH = 16,
   parameter int ITER  = 14
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             mode,
   input  logic [WIDTH-1:0] z0,
   input  logic             ysign,
   input  logic             stop,
   output logic [WIDTH-1:0] z,
   output logic             zsign,
   output logic [4:0]       iter,
   output logic             sub,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam int SH = 32 - WIDTH;
   localparam logic [4:0] LAST = 5'(ITER - 1);

   state_t           state;
   logic             mode_q;
   logic [31:0]      c;
   logic [WIDTH-1:0] step;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] sum;

   // Arctangent table, 2^31 = pi; entry 0 is fixed at 2^28.
   function automatic logic [31:0] atan_c(input logic [4:0] i);
      logic [31:0] r;
      r = 32'h0;
      case (i)
         5'd0:    r = 32'h1000_0000;
         5'd1:    r = 32'h12E4_051E;
         5'd2:    r = 32'h09FB_385B;
         5'd3:    r = 32'h0511_11D4;
         5'd4:    r = 32'h028B_0D43;
         5'd5:    r = 32'h0145_D7E1;
         5'd6:    r = 32'h00A2_F61E;
         5'd7:    r = 32'h0051_7C55;
         5'd8:    r = 32'h0028_BE53;
         5'd9:    r = 32'h0014_5F2F;
         5'd10:   r = 32'h000A_2F98;
         5'd11:   r = 32'h0005_17CC;
         5'd12:   r = 32'h0002_8BE6;
         5'd13:   r = 32'h0001_45F3;
         5'd14:   r = 32'h0000_A2FA;
         5'd15:   r = 32'h0000_517D;
         5'd16:   r = 32'h0000_28BE;
         5'd17:   r = 32'h0000_145F;
         5'd18:   r = 32'h0000_0A30;
         5'd19:   r = 32'h0000_0518;
         5'd20:   r = 32'h0000_028C;
         5'd21:   r = 32'h0000_0146;
         5'd22:   r = 32'h0000_00A3;
         5'd23:   r = 32'h0000_0051;
         default: r = 32'h0;
      endcase
      return r;
   endfunction

   // Look up the full-precision constant for the current step.
   always_comb begin
      c = atan_c(iter);
   end

   // Scale the constant to WIDTH bits with round-half-up.
   if (SH == 0) begin : g_full
      assign step = c[WIDTH-1:0];
   end else begin : g_round
      logic [32:0] rnd;
      logic        unused_bits;
      assign rnd  = {1'b0, c} + (33'd1 << (SH - 1));
      assign step = rnd[SH +: WIDTH];
      assign unused_bits = ^{rnd[32], rnd[SH-1:0]};
   end

   // Direction: sign of z in rotation, sign of y in vectoring.
   always_comb begin
      sub = 1'b0;
      if (state == RUN) begin
         sub = mode_q ? ysign : ~z[WIDTH-1];
      end
   end

   // One adder: invert operand and carry in for subtraction.
   always_comb begin
      opnd = step ^ {WIDTH{sub}};
      sum  = z + opnd + {{(WIDTH-1){1'b0}}, sub};
   end

   assign zsign = z[WIDTH-1];
   assign busy  = (state == RUN);

   // Sequencer: load on start, step per edge, pulse done at the end.
   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         z      <= '0;
         iter   <= '0;
         mode_q <= 1'b0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (!stop) begin
            case (state)
               IDLE: begin
                  if (start) begin
                     z      <= z0;
                     iter   <= '0;
                     mode_q <= mode;
                     state  <= RUN;
                  end
               end
               RUN: begin
                  z <= sum;
                  if (iter == LAST) begin
                     iter  <= '0;
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     iter <= iter + 5'd1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_znew_seq.sv
// tb_znew_seq: directed and randomized checks of znew_seq
// against a cycle-level arithmetic reference model.
module tb_znew_seq;

   logic        clk = 1'b0;
   logic        reset, start, mode, ysign, stop;
   logic [15:0] z0;
   logic [15:0] z;
   logic        zsign;
   logic [4:0]  iter;
   logic        sub, busy, done;

   int checks = 0;
   int errors = 0;

   // atan(2^-i) in 16-bit binary angles (32768 = pi), entry 0 = 4096
   int tab [0:13] = '{4096, 4836, 2555, 1297, 651, 326, 163,
                      81, 41, 20, 10, 5, 3, 1};

   logic [15:0] zm;
   logic [15:0] zobs [0:14];

   znew_seq dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .mode  (mode),
      .z0    (z0),
      .ysign (ysign),
      .stop  (stop),
      .z     (z),
      .zsign (zsign),
      .iter  (iter),
      .sub   (sub),
      .busy  (busy),
      .done  (done)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs,
                      input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag,
                $signed(obs), $signed(exp));
      end
   endtask

   // One operation; yk: 0/1 fixed ysign, 2 random per step.
   // Optional stop burst of slen cycles before step sat.
   task automatic op(input logic m, input logic [15:0] a0,
                     input int yk, input int sat, input int slen);
      logic s;
      start = 1'b1;
      mode  = m;
      z0    = a0;
      tick();
      mode  = 1'($urandom);
      z0    = 16'($urandom);
      zm    = a0;
      for (int i = 0; i < 14; i++) begin
         if (i == sat) begin
            stop = 1'b1;
            for (int k = 0; k < slen; k++) begin
               start = 1'($urandom);
               @(negedge clk);
               chk("stall_iter", 16'(iter), 16'(i));
               chk("stall_z", z, zm);
               chk("stall_busy", 16'(busy), 16'd1);
               chk("stall_done", 16'(done), 16'd0);
               tick();
            end
            stop = 1'b0;
         end
         start = 1'($urandom);
         ysign = (yk == 2) ? 1'($urandom) : 1'(yk);
         @(negedge clk);
         s = m ? ysign : ~zm[15];
         zobs[i] = z;
         chk("sub", 16'(sub), 16'(s));
         chk("iter", 16'(iter), 16'(i));
         chk("z", z, zm);
         chk("busy", 16'(busy), 16'd1);
         chk("done_early", 16'(done), 16'd0);
         zm = s ? zm - 16'(tab[i]) : zm + 16'(tab[i]);
         tick();
      end
      start = 1'b0;
      zobs[14] = z;
      chk("end_z", z, zm);
      chk("end_zsign", 16'(zsign), 16'(zm[15]));
      chk("end_busy", 16'(busy), 16'd0);
      chk("end_done", 16'(done), 16'd1);
      chk("end_iter", 16'(iter), 16'd0);
      chk("end_sub", 16'(sub), 16'd0);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b1;
      mode  = 1'b1;
      stop  = 1'b1;
      ysign = 1'b0;
      z0    = 16'h1234;
      tick();
      tick();
      chk("rst_z", z, 16'd0);
      chk("rst_iter", 16'(iter), 16'd0);
      chk("rst_busy", 16'(busy), 16'd0);
      chk("rst_done", 16'(done), 16'd0);
      chk("rst_sub", 16'(sub), 16'd0);
      reset = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      tick();
      chk("idle_busy", 16'(busy), 16'd0);

      // start while stopped is ignored
      stop  = 1'b1;
      start = 1'b1;
      z0    = 16'd1234;
      tick();
      chk("stopstart_busy", 16'(busy), 16'd0);
      chk("stopstart_z", z, 16'd0);
      stop  = 1'b0;
      start = 1'b0;
      tick();

      // rotation from 4096
      op(1'b0, 16'd4096, 0, -1, 0);
      chk("rot_e1", zobs[1], 16'd0);
      chk("rot_e2", zobs[2], 16'(-4836));
      chk("rot_e3", zobs[3], 16'(-2281));
      tick();
      chk("rot_done_clr", 16'(done), 16'd0);

      // vectoring with y negative and positive
      op(1'b1, 16'd0, 1, -1, 0);
      chk("vec_neg_e3", zobs[3], 16'(-11487));
      tick();
      op(1'b1, 16'd0, 0, -1, 0);
      chk("vec_pos_e3", zobs[3], 16'd11487);
      tick();

      // wrap past +pi
      op(1'b1, 16'd32767, 0, -1, 0);
      chk("wrap_e1", zobs[1], 16'(-28673));
      tick();

      // stop for 3 cycles after E2
      op(1'b0, 16'd4096, 0, 2, 3);
      chk("stop_frozen", zobs[2], 16'(-4836));
      // done clears even while stopped
      stop = 1'b1;
      tick();
      chk("stop_done_clr", 16'(done), 16'd0);
      chk("stop_hold_z", z, zm);
      stop = 1'b0;
      tick();

      // reset in mid-run
      start = 1'b1;
      mode  = 1'b0;
      z0    = 16'd4096;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      chk("mid_busy", 16'(busy), 16'd1);
      reset = 1'b1;
      start = 1'b1;
      tick();
      chk("midrst_z", z, 16'd0);
      chk("midrst_iter", 16'(iter), 16'd0);
      chk("midrst_busy", 16'(busy), 16'd0);
      chk("midrst_done", 16'(done), 16'd0);
      reset = 1'b0;
      start = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("midrst_nodone", 16'(done), 16'd0);
      end
      chk("midrst_idle", 16'(busy), 16'd0);

      // back-to-back: second start in the done cycle
      op(1'b0, 16'd1000, 0, -1, 0);
      op(1'b1, 16'(-2000), 2, -1, 0);
      tick();
      chk("b2b_done_clr", 16'(done), 16'd0);

      // randomized operations
      for (int n = 0; n < 24; n++) begin
         int sat;
         int slen;
         sat  = ($urandom % 3 == 0) ? int'($urandom % 14) : -1;
         slen = 1 + int'($urandom % 4);
         op(1'($urandom), 16'($urandom), 2, sat, slen);
         if ($urandom % 2 == 1) begin
            tick();
            chk("rnd_done_clr", 16'(done), 16'd0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
